// File: rtl/mc_pkg.sv
// Shared types and default widths for the Monte Carlo integrator blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

    // Default widths shared by the function stage, the RNG and the accumulator.
    localparam int MC_T_WIDTH = 16;
    localparam int MC_CNT_W   = 20;

    // Accumulator run-control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } mc_acc_state_e;

endpackage : mc_pkg

// File: rtl/mc_hit_compare.sv
// Registered hit classifier: flags a sample as a hit when z <= t (unsigned, full width).
// Latency: 1 cycle from an accepted sample to hit_o/hit_vld_o.
// Backpressure: none; hit_vld_o follows acc_i each cycle and drops when nothing is accepted.
module mc_hit_compare
    import mc_pkg::*;
#(
    parameter int T_WIDTH = MC_T_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               acc_i,
    input  logic [T_WIDTH-1:0] t_i,
    input  logic [T_WIDTH-1:0] z_i,
    output logic               hit_o,
    output logic               hit_vld_o
);

    logic hit_q;
    logic hit_vld_q;

    // Capture the compare result of an accepted sample; the valid flag lasts one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            hit_q     <= 1'b0;
            hit_vld_q <= 1'b0;
        end else begin
            hit_vld_q <= acc_i;
            if (acc_i) begin
                hit_q <= (z_i <= t_i);
            end
        end
    end

    assign hit_o     = hit_q;
    assign hit_vld_o = hit_vld_q;

endmodule : mc_hit_compare

// File: rtl/mc_hit_accumulator.sv
// Counts accepted samples and hits (z <= t) over a run of n_samples, then pulses done.
// Latency: hit visible in hits_o 2 edges after acceptance; done 1 cycle after the FLUSH cycle.
// Backpressure: in_ready_o high only in RUN; in_valid_o gaps stall the run without timeout.
module mc_hit_accumulator
    import mc_pkg::*;
#(
    parameter int T_WIDTH = MC_T_WIDTH,
    parameter int CNT_W   = MC_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   n_samples_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [T_WIDTH-1:0] in_t_i,
    input  logic [T_WIDTH-1:0] in_z_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   hits_o,
    output logic [CNT_W-1:0]   total_o
);

    mc_acc_state_e    state_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] hits_q;
    logic [CNT_W-1:0] hits_d;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             start_take;
    logic             hit;
    logic             hit_vld;

    // in_ready_q mirrors state == RUN, so accept needs no extra state decode.
    assign accept     = in_valid_i && in_ready_q;
    assign start_take = start_i && (state_q == IDLE);

    mc_hit_compare #(
        .T_WIDTH (T_WIDTH)
    ) u_cmp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (start_take),
        .acc_i     (accept),
        .t_i       (in_t_i),
        .z_i       (in_z_i),
        .hit_o     (hit),
        .hit_vld_o (hit_vld)
    );

    // Run control: state, latched run length, sample count and registered status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            n_q        <= '0;
            total_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        n_q     <= n_samples_i;
                        total_q <= '0;
                        busy_q  <= 1'b1;
                        if (n_samples_i == '0) begin
                            // Empty run: skip straight to the flush/report tail.
                            state_q    <= FLUSH;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid_i) begin
                        total_q <= total_q + CNT_W'(1);
                        if ((total_q + CNT_W'(1)) == n_q) begin
                            state_q    <= FLUSH;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // The last compare result drains into hits during this cycle.
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // Hit count folds in the one-cycle-delayed compare result; cleared on an accepted start.
    always_comb begin
        hits_d = hits_q;
        if (start_take) begin
            hits_d = '0;
        end else if (hit_vld && hit) begin
            hits_d = hits_q + CNT_W'(1);
        end
    end

    // Hit counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hits_q <= '0;
        end else begin
            hits_q <= hits_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hits_o     = hits_q;
    assign total_o    = total_q;

endmodule : mc_hit_accumulator

// File: tb/tb_mc_hit_accumulator.sv
module tb_mc_hit_accumulator;

    localparam int TW = 16;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] n_samples;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_t;
    logic [TW-1:0] in_z;
    logic          busy;
    logic          done;
    logic [CW-1:0] hits;
    logic [CW-1:0] total;

    int checks = 0;
    int errors = 0;

    // Directed sample/valid queues; when empty the run uses random values.
    logic [TW-1:0] qt[$];
    logic [TW-1:0] qz[$];
    bit            qv[$];

    always #5 clk = ~clk;

    mc_hit_accumulator #(
        .T_WIDTH (TW),
        .CNT_W   (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .n_samples_i (n_samples),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_t_i      (in_t),
        .in_z_i      (in_z),
        .busy_o      (busy),
        .done_o      (done),
        .hits_o      (hits),
        .total_o     (total)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run. The model counts hits with z <= t over accepted samples,
    // delays each hit by one edge before it shows in hits, and expects done one
    // edge after the edge that accepts the last sample.
    task automatic do_run(input string tag, input int n, input int gap_pct,
                          input bit poke_mid, input bit poke_done);
        int            acc;
        int            gaps;
        int            edges;
        int            waited;
        int            exp_hits;
        bit            pend;
        bit            v;
        logic [TW-1:0] t;
        logic [TW-1:0] z;
        acc      = 0;
        gaps     = 0;
        edges    = 0;
        exp_hits = 0;
        pend     = 1'b0;

        start     = 1'b1;
        n_samples = CW'(n);
        tick();
        start     = 1'b0;
        n_samples = CW'($urandom_range(1, 50));
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_rdy_start"}, in_ready, (n != 0));
        check({tag, "_hits_clr"}, hits, 0);
        check({tag, "_total_clr"}, total, 0);

        while (acc < n) begin
            if (qv.size() > 0) v = qv.pop_front();
            else               v = ($urandom_range(99) >= gap_pct);
            if (v && qt.size() > 0) t = qt.pop_front(); else t = TW'($urandom);
            if (v && qz.size() > 0) z = qz.pop_front(); else z = TW'($urandom);
            if (n <= 8 || acc % 50 == 0) check({tag, "_rdy_run"}, in_ready, 1);
            in_valid = v;
            in_t     = t;
            in_z     = z;
            start    = poke_mid && (edges == 1);
            tick();
            edges++;
            start    = 1'b0;
            exp_hits += int'(pend);
            pend      = v && (z <= t);
            if (v) acc++;
            else   gaps++;
            if (n <= 8 || acc % 50 == 0) begin
                check({tag, "_hits_run"}, hits, exp_hits);
                check({tag, "_total_run"}, total, acc);
                check({tag, "_done_early"}, done, 0);
            end
        end
        in_valid = 1'b0;
        in_t     = TW'($urandom);
        in_z     = TW'($urandom);
        check({tag, "_rdy_flush"}, in_ready, 0);
        check({tag, "_busy_flush"}, busy, 1);

        waited = 0;
        while (!done && waited < 6) begin
            tick();
            waited++;
            edges++;
        end
        exp_hits += int'(pend);
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, edges, n + gaps + 1);
        check({tag, "_hits"}, hits, exp_hits);
        check({tag, "_total"}, total, n);
        check({tag, "_busy_done"}, busy, 0);

        if (poke_done) begin
            start     = 1'b1;
            n_samples = CW'(9);
        end
        tick();
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_rdy_idle"}, in_ready, 0);
        check({tag, "_hits_hold"}, hits, exp_hits);
        check({tag, "_total_hold"}, total, n);
        tick();
        check({tag, "_busy_idle2"}, busy, 0);
        check({tag, "_hits_hold2"}, hits, exp_hits);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        n_samples = '0;
        in_valid  = 1'b0;
        in_t      = '0;
        in_z      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdy", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hits", hits, 0);
        check("rst_total", total, 0);
        tick();

        // Basic run: 3 hits of 4, back-to-back.
        qt = '{16'd100, 16'd100, 16'd100, 16'd0};
        qz = '{16'd50,  16'd100, 16'd101, 16'd0};
        qv = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_run("n4", 4, 0, 1'b0, 1'b0);
        check("n4_hits_const", hits, 3);

        // Empty run.
        do_run("n0", 0, 0, 1'b0, 1'b0);
        check("n0_hits_const", hits, 0);

        // Valid gaps; all hits.
        qt = '{16'd500, 16'd7, 16'd1234};
        qz = '{16'd10,  16'd7, 16'd0};
        qv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_run("gaps", 3, 0, 1'b0, 1'b0);
        check("gaps_hits_const", hits, 3);

        // Full-width boundary compares.
        qt = '{16'hFFFF, 16'h0000, 16'hFFFF};
        qz = '{16'hFFFF, 16'h0001, 16'h0000};
        qv = '{1'b1, 1'b1, 1'b1};
        do_run("bound", 3, 0, 1'b0, 1'b0);
        check("bound_hits_const", hits, 2);

        // start pulses mid-run and during DONE are ignored.
        do_run("poke", 6, 20, 1'b1, 1'b1);

        // Reset after 2 of 5 samples discards the run.
        start     = 1'b1;
        n_samples = CW'(5);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_t     = 16'd10;
        in_z     = 16'd1;
        tick();
        tick();
        in_valid = 1'b0;
        check("mid_total", total, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_hits", hits, 0);
        check("rstmid_total", total, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_rdy", in_ready, 0);
        check("rstmid_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstmid_nodone", done, 0);
            check("rstmid_idle", busy, 0);
        end
        do_run("after_rst", 5, 25, 1'b0, 1'b0);

        // Random regression: 10k samples with random gaps.
        for (int r = 0; r < 20; r++) begin
            do_run("rand", 500, 30, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mc_hit_accumulator
